// File: rtl/fire_codec.sv
// Serial Fire-code codec: systematic encode by G-division LFSR, decode by syndrome
// computation followed by backward error trapping of a single burst of up to B bits.
module fire_codec #(
    parameter int           N      = 64,
    parameter int           K      = 40,
    parameter int           C      = 15,
    parameter int           M      = 9,
    parameter logic [M-1:0] P_POLY = 9'h011
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 mode_i,
    input  logic [N-1:0]         data_in_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [N-1:0]         data_out_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 err_det_o,
    output logic                 err_corr_o,
    output logic                 err_uncorr_o,
    output logic [$clog2(N)-1:0] err_pos_o
);

    localparam int R  = N - K;
    localparam int B  = (M < (C + 1) / 2) ? M : (C + 1) / 2;
    localparam int CW = $clog2(N + 1);
    localparam int PW = $clog2(N);

    function automatic logic [R:0] gen_poly();
        logic [R:0] p_full;
        p_full        = '0;
        p_full[M:0]   = {1'b1, P_POLY};
        return (p_full << C) ^ p_full;
    endfunction

    localparam logic [R:0] G = gen_poly();

    // IDLE accept | ENC parity division | SYN syndrome | TRAP burst search | DONE hold result
    typedef enum logic [2:0] {S_IDLE, S_ENC, S_SYN, S_TRAP, S_DONE} state_t;

    state_t        state_q;
    logic [N-1:0]  data_q;
    logic [N-1:0]  sh_q;
    logic [R-1:0]  rem_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  out_q;
    logic          det_q, corr_q, uncorr_q;
    logic [PW-1:0] pos_q;

    logic          enc_fb;
    logic [R-1:0]  enc_rem_d;
    logic [R-1:0]  syn_rem_d;
    logic [R-1:0]  trap_rem_d;
    logic          burst_fits;
    logic          trap_match;
    logic [N-1:0]  corr_word;

    always_comb begin
        enc_fb     = sh_q[N-1] ^ rem_q[R-1];
        enc_rem_d  = {rem_q[R-2:0], 1'b0} ^ (enc_fb ? G[R-1:0] : '0);
        syn_rem_d  = {rem_q[R-2:0], sh_q[N-1]} ^ (rem_q[R-1] ? G[R-1:0] : '0);
        // Multiply by x^-1 mod G: an odd remainder first absorbs G, whose x^R term lands on bit R-1.
        trap_rem_d = rem_q[0] ? {1'b1, rem_q[R-1:1] ^ G[R-1:1]} : {1'b0, rem_q[R-1:1]};
        burst_fits = 1'b1;
        for (int j = 0; j < B; j++) begin
            if (rem_q[j] && (int'(cnt_q) + j > N - 1)) burst_fits = 1'b0;
        end
        trap_match = rem_q[0] && (rem_q[R-1:B] == '0) && burst_fits;
        corr_word  = data_q ^ ({{(N-B){1'b0}}, rem_q[B-1:0]} << cnt_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            data_q   <= '0;
            sh_q     <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            det_q    <= 1'b0;
            corr_q   <= 1'b0;
            uncorr_q <= 1'b0;
            pos_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i) begin
                        data_q   <= data_in_i;
                        rem_q    <= '0;
                        cnt_q    <= '0;
                        det_q    <= 1'b0;
                        corr_q   <= 1'b0;
                        uncorr_q <= 1'b0;
                        pos_q    <= '0;
                        if (mode_i) begin
                            sh_q    <= data_in_i;
                            state_q <= S_SYN;
                        end else begin
                            sh_q    <= {data_in_i[K-1:0], {R{1'b0}}};
                            state_q <= S_ENC;
                        end
                    end
                end
                S_ENC: begin
                    rem_q <= enc_rem_d;
                    sh_q  <= sh_q << 1;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(K - 1)) begin
                        out_q   <= {data_q[K-1:0], enc_rem_d};
                        state_q <= S_DONE;
                    end
                end
                S_SYN: begin
                    rem_q <= syn_rem_d;
                    sh_q  <= sh_q << 1;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        cnt_q <= '0;
                        if (syn_rem_d == '0) begin
                            out_q   <= data_q;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_TRAP;
                        end
                    end
                end
                S_TRAP: begin
                    if (trap_match) begin
                        out_q   <= corr_word;
                        det_q   <= 1'b1;
                        corr_q  <= 1'b1;
                        pos_q   <= cnt_q[PW-1:0];
                        state_q <= S_DONE;
                    end else if (cnt_q == CW'(N - 1)) begin
                        out_q    <= data_q;
                        det_q    <= 1'b1;
                        uncorr_q <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        rem_q <= trap_rem_d;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready_i) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o   = (state_q == S_IDLE);
    assign out_valid_o  = (state_q == S_DONE);
    assign data_out_o   = out_q;
    assign err_det_o    = det_q;
    assign err_corr_o   = corr_q;
    assign err_uncorr_o = uncorr_q;
    assign err_pos_o    = pos_q;

endmodule

// File: tb/tb_fire_codec.sv
// Directed bench for fire_codec at default parameters (64/40, G = x^24+x^19+x^15+x^9+x^4+1).
module tb_fire_codec;
    localparam int N = 64;
    localparam int K = 40;
    localparam int R = 24;
    localparam logic [63:0] G_TB = 64'h1088211;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        mode_i;
    logic [63:0] data_in_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [63:0] data_out_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        err_det_o, err_corr_o, err_uncorr_o;
    logic [5:0]  err_pos_o;

    int n_checks = 0;
    int n_fail   = 0;

    fire_codec dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .mode_i      (mode_i),
        .data_in_i   (data_in_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .data_out_o  (data_out_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .err_det_o   (err_det_o),
        .err_corr_o  (err_corr_o),
        .err_uncorr_o(err_uncorr_o),
        .err_pos_o   (err_pos_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Plain long division of v(x) by G, independent of any shift-register form.
    function automatic logic [R-1:0] syn_model(input logic [63:0] v);
        logic [63:0] w;
        w = v;
        for (int i = 63; i >= R; i--) begin
            if (w[i]) w = w ^ (G_TB << (i - R));
        end
        return w[R-1:0];
    endfunction

    // Brute force: earliest position t with an odd 8-bit burst whose syndrome matches.
    task automatic trap_model(input logic [63:0] rx, output bit corr, output int t_o,
                              output logic [7:0] pat_o);
        logic [R-1:0] s;
        logic [63:0]  e;
        s = syn_model(rx);
        corr = 1'b0; t_o = 0; pat_o = '0;
        for (int t = 0; t < N; t++) begin
            for (int b = 1; b < 256; b += 2) begin
                e = 64'(b) << t;
                if (!corr && ((e >> t) == 64'(b)) && (syn_model(e) == s)) begin
                    corr = 1'b1; t_o = t; pat_o = b[7:0];
                end
            end
        end
    endtask

    // Called #1 after a clock edge with the DUT idle; returns edges from accept to out_valid.
    task automatic run_txn(input logic m, input logic [63:0] din, output int lat);
        mode_i = m; data_in_i = din; in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0; mode_i = ~m; data_in_i = ~din;
        lat = 0;
        while (!out_valid_o && lat < 400) begin
            @(posedge clk_i); #1;
            lat++;
        end
    endtask

    task automatic finish_txn(input string tag);
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        check({tag, "_in_ready_after"}, 64'(in_ready_o), 64'd1);
        check({tag, "_out_valid_after"}, 64'(out_valid_o), 64'd0);
    endtask

    task automatic do_dec(input string tag, input logic [63:0] rx, input logic [63:0] exp_data,
                          input bit det, input bit corr, input bit uncorr, input int pos,
                          input int exp_lat);
        int lat;
        run_txn(1'b1, rx, lat);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_data"}, data_out_o, exp_data);
        check({tag, "_err_det"}, 64'(err_det_o), 64'(det));
        check({tag, "_err_corr"}, 64'(err_corr_o), 64'(corr));
        check({tag, "_err_uncorr"}, 64'(err_uncorr_o), 64'(uncorr));
        if (corr) check({tag, "_err_pos"}, 64'(err_pos_o), 64'(pos));
        finish_txn(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [63:0] cw_a5, rx, exp_bp;
        logic [39:0] msg;
        logic [7:0]  pat;
        bit          mcorr;
        int          mt;

        rst_ni = 1'b0; mode_i = 1'b0; data_in_i = '0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        #12;
        check("rst_in_ready", 64'(in_ready_o), 64'd1);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_data", data_out_o, 64'd0);
        check("rst_flags", {61'd0, err_det_o, err_corr_o, err_uncorr_o}, 64'd0);
        check("rst_pos", 64'(err_pos_o), 64'd0);
        #5 rst_ni = 1'b1;
        @(posedge clk_i); #1;

        run_txn(1'b0, 64'h0, lat);
        check("enc0_latency", 64'(lat), 64'd40);
        check("enc0_data", data_out_o, 64'h0);
        check("enc0_flags", {61'd0, err_det_o, err_corr_o, err_uncorr_o}, 64'd0);
        finish_txn("enc0");

        msg   = 40'hA5_5A5A_5A5A;
        cw_a5 = {msg, syn_model({msg, 24'h0})};
        run_txn(1'b0, {24'hFFFFFF, msg}, lat);
        check("enc_a5_latency", 64'(lat), 64'd40);
        check("enc_a5_data", data_out_o, cw_a5);
        check("enc_a5_flags", {61'd0, err_det_o, err_corr_o, err_uncorr_o}, 64'd0);
        finish_txn("enc_a5");

        do_dec("dec_a5_clean", cw_a5, cw_a5, 1'b0, 1'b0, 1'b0, 0, 64);

        // Abort a decode mid-syndrome while data_out still holds the previous codeword.
        mode_i = 1'b1; data_in_i = 64'h1; in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1 rst_ni = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid_o), 64'd0);
        check("midrst_in_ready", 64'(in_ready_o), 64'd1);
        check("midrst_data", data_out_o, 64'd0);
        check("midrst_flags", {61'd0, err_det_o, err_corr_o, err_uncorr_o}, 64'd0);
        check("midrst_pos", 64'(err_pos_o), 64'd0);
        #2 rst_ni = 1'b1;
        @(posedge clk_i); #1;

        do_dec("bit0", 64'h1, 64'h0, 1'b1, 1'b1, 1'b0, 0, 65);
        do_dec("bit63", 64'h1 << 63, 64'h0, 1'b1, 1'b1, 1'b0, 63, 128);
        do_dec("burst30", cw_a5 ^ (64'h81 << 30), cw_a5, 1'b1, 1'b1, 1'b0, 30, 95);

        for (int p = 0; p <= 56; p++) begin
            pat = 8'($urandom_range(255)) | 8'h01;
            do_dec($sformatf("sweep%0d", p), cw_a5 ^ (64'(pat) << p), cw_a5,
                   1'b1, 1'b1, 1'b0, p, N + p + 1);
        end

        rx = 64'h1 | (64'h1 << 20);
        trap_model(rx, mcorr, mt, pat);
        if (mcorr)
            do_dec("bits0_20", rx, rx ^ (64'(pat) << mt), 1'b1, 1'b1, 1'b0, mt, N + mt + 1);
        else
            do_dec("bits0_20", rx, rx, 1'b1, 1'b0, 1'b1, 0, 2 * N);

        msg    = 40'h12_3456_789A;
        exp_bp = {msg, syn_model({msg, 24'h0})};
        run_txn(1'b0, {24'h0, msg}, lat);
        check("bp_latency", 64'(lat), 64'd40);
        for (int i = 0; i < 5; i++) begin
            in_valid_i = (i >= 1 && i <= 3);
            mode_i     = 1'b1;
            data_in_i  = 64'hDEAD_BEEF_0000_0000 | 64'(i);
            @(posedge clk_i); #1;
            check($sformatf("bp_out_valid%0d", i), 64'(out_valid_o), 64'd1);
            check($sformatf("bp_in_ready%0d", i), 64'(in_ready_o), 64'd0);
            check($sformatf("bp_data%0d", i), data_out_o, exp_bp);
        end
        in_valid_i = 1'b0;
        finish_txn("bp");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
